// File: rtl/y_pulse_counter.sv
// y_pulse_counter
//   Synchronises a glitchy combinational input `y_in` into the `clk` domain,
//   optionally debounces it, detects accepted rising edges and counts them
//   over a fixed window. At each window expiry the count is snapshotted onto
//   a valid/ready output, together with a saturation flag.
//
// Build option:
//   Y_PULSE_COUNTER_DEBOUNCE_EN  defined   -> debounce filter compiled in
//                                undefined -> debounced level is y_sync
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   y_in       in   asynchronous upstream level
//   clr        in   synchronous clear of counter/window/output path
//   edge_pulse out  one-cycle strobe per accepted rising edge
//   cnt_out    out  last window's event count
//   cnt_ovf    out  count saturated during that window
//   cnt_valid  out  snapshot available
//   cnt_ready  in   consumer accepts snapshot
//   miss       out  one-cycle strobe, unaccepted snapshot overwritten
module y_pulse_counter #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8,
    parameter int unsigned WINDOW          = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             y_in,
    input  logic             clr,
    output logic             edge_pulse,
    output logic [CNT_W-1:0] cnt_out,
    output logic             cnt_ovf,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             miss
);

    localparam int unsigned TMR_W = $clog2(WINDOW);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW - 1);

    // Elaboration-time parameter checks.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if (WINDOW < 2) begin : g_bad_win
        $error("WINDOW must be at least 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("CNT_W must be at least 1");
    end

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   y_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], y_in};
        end
    end

    assign y_sync = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce filter
    // ------------------------------------------------------------------
    logic deb_level;

`ifdef Y_PULSE_COUNTER_DEBOUNCE_EN
    localparam int unsigned STAB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_CYCLES - 1);

    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
    logic              deb_level_q, deb_level_d;

    // A new level is taken only after DEBOUNCE_CYCLES consecutive differing
    // samples; any sample matching the current level restarts the run.
    always_comb begin
        stab_cnt_d  = stab_cnt_q;
        deb_level_d = deb_level_q;
        if (y_sync == deb_level_q) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_MAX) begin
            deb_level_d = y_sync;
            stab_cnt_d  = '0;
        end else begin
            stab_cnt_d = stab_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stab_cnt_q  <= '0;
            deb_level_q <= 1'b0;
        end else begin
            stab_cnt_q  <= stab_cnt_d;
            deb_level_q <= deb_level_d;
        end
    end

    assign deb_level = deb_level_q;
`else
    assign deb_level = y_sync;
`endif

    // ------------------------------------------------------------------
    // Edge detect
    // ------------------------------------------------------------------
    logic deb_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_prev_q <= 1'b0;
        end else begin
            deb_prev_q <= deb_level;
        end
    end

    // Both terms are flop outputs, so the strobe cannot glitch.
    assign edge_pulse = deb_level & ~deb_prev_q;

    // ------------------------------------------------------------------
    // Event counter, window timer and snapshot
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             ovf_q, ovf_d, ovf_inc;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] snap_q, snap_d;
    logic             snap_ovf_q, snap_ovf_d;
    logic             valid_q, valid_d;
    logic             miss_q, miss_d;
    logic             cnt_sat;
    logic             expire;

    assign cnt_sat = (cnt_q == {CNT_W{1'b1}});
    assign expire  = (timer_q == TMR_LAST);

    // Count including this cycle's edge, so an edge on the expiry cycle
    // lands in the closing window.
    assign cnt_inc = (edge_pulse && !cnt_sat) ? cnt_q + 1'b1 : cnt_q;
    assign ovf_inc = ovf_q | (edge_pulse & cnt_sat);

    always_comb begin
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        timer_d    = timer_q;
        snap_d     = snap_q;
        snap_ovf_d = snap_ovf_q;
        valid_d    = valid_q;
        miss_d     = 1'b0;
        if (clr) begin
            cnt_d      = '0;
            ovf_d      = 1'b0;
            timer_d    = '0;
            snap_d     = '0;
            snap_ovf_d = 1'b0;
            valid_d    = 1'b0;
        end else if (expire) begin
            snap_d     = cnt_inc;
            snap_ovf_d = ovf_inc;
            valid_d    = 1'b1;
            // Overwriting a snapshot the consumer has not taken.
            miss_d     = valid_q & ~cnt_ready;
            cnt_d      = '0;
            ovf_d      = 1'b0;
            timer_d    = '0;
        end else begin
            cnt_d   = cnt_inc;
            ovf_d   = ovf_inc;
            timer_d = timer_q + 1'b1;
            if (valid_q && cnt_ready) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            timer_q    <= '0;
            snap_q     <= '0;
            snap_ovf_q <= 1'b0;
            valid_q    <= 1'b0;
            miss_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            timer_q    <= timer_d;
            snap_q     <= snap_d;
            snap_ovf_q <= snap_ovf_d;
            valid_q    <= valid_d;
            miss_q     <= miss_d;
        end
    end

    assign cnt_out   = snap_q;
    assign cnt_ovf   = snap_ovf_q;
    assign cnt_valid = valid_q;
    assign miss      = miss_q;

endmodule

// File: tb/tb_y_pulse_counter.sv
module tb_y_pulse_counter;

    localparam int SYNC = 2;
    localparam int DEB_CYC = 4;
    localparam int CW = 3;
    localparam int WIN = 100;
`ifdef Y_PULSE_COUNTER_DEBOUNCE_EN
    localparam int DEB = DEB_CYC;
`else
    localparam int DEB = 0;
`endif
    // Edges from y_in rising (set just after edge e0) to the counter increment.
    localparam int LAT = SYNC + DEB + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          y_in;
    logic          clr;
    logic          edge_pulse;
    logic [CW-1:0] cnt_out;
    logic          cnt_ovf;
    logic          cnt_valid;
    logic          cnt_ready;
    logic          miss;

    int n_checks = 0;
    int n_errors = 0;
    int t = 0;
    int base_c;
    int base_c2;
    int seen;

    logic [CW:0] exp_q[$];

    y_pulse_counter #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB_CYC),
        .CNT_W          (CW),
        .WINDOW         (WIN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .y_in      (y_in),
        .clr       (clr),
        .edge_pulse(edge_pulse),
        .cnt_out   (cnt_out),
        .cnt_ovf   (cnt_ovf),
        .cnt_valid (cnt_valid),
        .cnt_ready (cnt_ready),
        .miss      (miss)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, t);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
        t += n;
    endtask

    task automatic wait_to(input int n);
        while (t < n) step(1);
    endtask

    // Pulse whose counter increment lands on edge cnt_edge.
    task automatic pulse_at(input int cnt_edge);
        wait_to(cnt_edge - LAT);
        y_in = 1'b1;
        step(5);
        y_in = 1'b0;
    endtask

    // Scoreboard monitor: a transfer happens on the next posedge.
    always @(negedge clk) begin
        if (!rst && cnt_valid && cnt_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL snapshot: got transfer cnt=%0d ovf=%0b, expected none",
                         cnt_out, cnt_ovf);
            end else begin
                logic [CW:0] e;
                e = exp_q.pop_front();
                if ({cnt_ovf, cnt_out} !== e) begin
                    n_errors++;
                    $display("FAIL snapshot: got cnt=%0d ovf=%0b, expected cnt=%0d ovf=%0b",
                             cnt_out, cnt_ovf, e[CW-1:0], e[CW]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        y_in = 1'b0;
        clr = 1'b0;
        cnt_ready = 1'b0;
        #2;
        check("reset_edge_pulse", edge_pulse, 0);
        check("reset_valid", cnt_valid, 0);
        check("reset_cnt_out", cnt_out, 0);
        check("reset_miss", miss, 0);
        #10;
        rst = 1'b0;
        t = 0;
        // Latency: y_in rises before edge 1 and is held.
        y_in = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            check("latency_edge_pulse", edge_pulse, (k == SYNC + DEB) ? 1 : 0);
        end
        y_in = 1'b0;
`ifdef Y_PULSE_COUNTER_DEBOUNCE_EN
        wait_to(30);
        y_in = 1'b1;
        step(3);
        y_in = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            if (edge_pulse) seen++;
        end
        check("debounce_3wide", seen, 0);
        y_in = 1'b1;
        step(4);
        y_in = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            step(1);
            if (edge_pulse) seen++;
        end
        check("debounce_4wide", seen, 1);
`endif
        // Align the window with a clear.
        wait_to(70);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        base_c = t;
        cnt_ready = 1'b1;

        // Window A: 7 clean pulses.
        exp_q.push_back({1'b0, 3'd7});
        for (int i = 1; i <= 7; i++) pulse_at(base_c + 10 * i);
        wait_to(base_c + WIN - 1);
        check("winA_valid_before", cnt_valid, 0);
        wait_to(base_c + WIN);
        check("winA_valid", cnt_valid, 1);
        check("winA_cnt", cnt_out, 7);
        wait_to(base_c + WIN + 1);
        check("winA_valid_one_cycle", cnt_valid, 0);

        // Window B: second pulse increments exactly on the expiry edge.
        exp_q.push_back({1'b0, 3'd2});
        pulse_at(base_c + 150);
        pulse_at(base_c + 200);
        wait_to(base_c + 200);
        check("winB_expiry_edge_cnt", cnt_out, 2);

        // Window C: 10 pulses saturate a 3-bit counter.
        exp_q.push_back({1'b1, 3'd7});
        for (int i = 0; i < 10; i++) pulse_at(base_c + 210 + 9 * i);
        wait_to(base_c + 300);
        check("winC_ovf", cnt_ovf, 1);

        // Window D: saturation flag clears.
        exp_q.push_back({1'b0, 3'd2});
        pulse_at(base_c + 320);
        pulse_at(base_c + 340);
        wait_to(base_c + 400);
        check("winD_ovf", cnt_ovf, 0);
        wait_to(base_c + 401);
        cnt_ready = 1'b0;

        // Window E held, overwritten by window F.
        pulse_at(base_c + 450);
        wait_to(base_c + 500);
        check("winE_valid", cnt_valid, 1);
        check("winE_miss", miss, 0);
        exp_q.push_back({1'b0, 3'd3});
        pulse_at(base_c + 520);
        pulse_at(base_c + 530);
        pulse_at(base_c + 540);
        wait_to(base_c + 600);
        check("winF_miss", miss, 1);
        check("winF_cnt", cnt_out, 3);
        wait_to(base_c + 601);
        check("winF_miss_one_cycle", miss, 0);

        // Window G: accept on the same edge as expiry.
        pulse_at(base_c + 650);
        wait_to(base_c + 699);
        cnt_ready = 1'b1;
        step(1);
        cnt_ready = 1'b0;
        check("winG_valid_stays", cnt_valid, 1);
        check("winG_miss", miss, 0);
        check("winG_cnt", cnt_out, 1);

        // Clear mid-window with a snapshot pending.
        wait_to(base_c + 749);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        base_c2 = t;
        check("clr_valid", cnt_valid, 0);
        check("clr_cnt", cnt_out, 0);
        pulse_at(base_c2 + 30);
        wait_to(base_c2 + WIN - 1);
        check("clr_window_early", cnt_valid, 0);
        wait_to(base_c2 + WIN);
        check("clr_window_valid", cnt_valid, 1);
        check("clr_window_cnt", cnt_out, 1);

        // Reset mid-operation while edge_pulse and cnt_valid are high.
        wait_to(base_c2 + 130 - LAT);
        y_in = 1'b1;
        wait_to(base_c2 + 129);
        check("pre_rst_edge_pulse", edge_pulse, 1);
        #1;
        rst = 1'b1;
        y_in = 1'b0;
        #1;
        check("rst_edge_pulse", edge_pulse, 0);
        check("rst_valid", cnt_valid, 0);
        check("rst_cnt_out", cnt_out, 0);
        check("rst_miss", miss, 0);
        #2;
        rst = 1'b0;
        t = 0;
        wait_to(WIN - 1);
        check("post_rst_window_early", cnt_valid, 0);
        wait_to(WIN);
        check("post_rst_window_valid", cnt_valid, 1);
        check("post_rst_window_cnt", cnt_out, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/y_pulse_counter.md
# y_pulse_counter

- Downstream stage for a single combinational logic output `y`.
- Function:
  - synchronises `y` into the `clk` domain;
  - optionally debounces it;
  - detects rising edges and counts them over a fixed window of clock cycles;
  - presents each window's count on a valid/ready output with a saturation flag.
- Lets a team turn a glitchy combinational result into a measured event rate that a CPU or display stage can consume.

## Interface

Parameters:
- `SYNC_STAGES`, 2: synchroniser flop count, ≥2.
- `DEBOUNCE_CYCLES`, 4: consecutive identical samples needed to accept a new level, ≥1.
- `CNT_W`, 8: event counter / snapshot width.
- `WINDOW`, 1000: window length in `clk` cycles, ≥2.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `y_in` in 1: asynchronous input, the upstream `y`.
- `clr` in 1: synchronous clear of the count/window/output path.
- `edge_pulse` out 1: one-cycle strobe per accepted rising edge.
- `cnt_out` out `CNT_W`: last window's event count.
- `cnt_ovf` out 1: count saturated during that window.
- `cnt_valid` out 1: snapshot available.
- `cnt_ready` in 1: consumer accepts snapshot.
- `miss` out 1: one-cycle strobe, unaccepted snapshot overwritten.

## Operation

- Reset (`rst`=1, asynchronous): every flop clears to 0.
  - Sync chain, debounced level, `deb_prev`, debounce counter, event counter, window timer, snapshot, `cnt_ovf`, `cnt_valid`, `miss` all 0.
  - `edge_pulse` is therefore 0 during reset.
- Synchroniser: `y_in` → shift chain of `SYNC_STAGES` flops; `y_sync` = last flop.
- Debounce filter, per edge:
  - If `y_sync == deb_level`: `stab_cnt` ← 0.
  - Else if `stab_cnt == DEBOUNCE_CYCLES-1`: `deb_level` ← `y_sync` and `stab_cnt` ← 0.
  - Else: `stab_cnt` increments.
  - A pulse shorter than `DEBOUNCE_CYCLES` synchronised samples is discarded.
- Edge detect:
  - `deb_prev` ← `deb_level` every edge.
  - `edge_pulse` = `deb_level & ~deb_prev`, combinational from flops, glitch-free.
- Event counter:
  - Increments on each edge where `edge_pulse`=1.
  - Saturates at 2^`CNT_W`−1.
  - An increment attempt at saturation sets the internal `ovf` flag.
- Window timer:
  - Counts 0..`WINDOW`−1.
  - On the edge where timer == `WINDOW`−1 (expiry):
    - `cnt_out` ← counter, plus 1 (saturating) if `edge_pulse` is high that cycle; that edge counts in the closing window.
    - `cnt_ovf` ← `ovf`, including any overflow from that final increment.
    - `cnt_valid` ← 1.
    - Counter ← 0, `ovf` ← 0, timer ← 0.
- Output handshake:
  - A transfer occurs on an edge with `cnt_valid & cnt_ready`; `cnt_valid` ← 0 unless expiry occurs on the same edge.
  - Expiry with simultaneous accept: new snapshot loads, `cnt_valid` stays 1, `miss` stays 0.
  - Expiry with `cnt_valid`=1 and `cnt_ready`=0: snapshot is overwritten and `miss`=1 for the following cycle.
  - `cnt_out`/`cnt_ovf` are stable while `cnt_valid`=1 and no expiry occurs.
- `clr` (synchronous, highest priority over expiry and handshake):
  - Zeroes counter, `ovf`, timer, snapshot, `cnt_ovf`, `cnt_valid`, `miss`.
  - Does not touch the sync chain, debounce, or `deb_prev`; an edge pulse during `clr` is dropped.
- Reset mid-window discards all state; the first window after reset release is a full `WINDOW` cycles.

## Timing

- Input latency with default parameters:
  - `y_in` rises before edge 1 and is held.
  - `y_sync`=1 after edge `SYNC_STAGES` (2).
  - `deb_level`=1 after edge `SYNC_STAGES+DEBOUNCE_CYCLES` (6).
  - `edge_pulse` high for exactly the cycle after edge 6.
  - Counter increments on edge 7.
- Without debounce: `deb_level` = `y_sync`; `edge_pulse` is high the cycle after edge `SYNC_STAGES`.
- Window period:
  - Exactly `WINDOW` cycles.
  - The first expiry is on edge `WINDOW` after reset release or after `clr`.
- Edge rate: at most one `edge_pulse` per 2 cycles without debounce, and per 2·`DEBOUNCE_CYCLES` cycles with it.
- `cnt_valid` rises one edge after the expiry decision; the snapshot is visible in the same cycle.

## Configuration

- `Y_PULSE_COUNTER_DEBOUNCE_EN` defined: the debounce filter and `stab_cnt` are compiled in, behaving as above.
- Undefined:
  - The filter is removed and `deb_level` is wired to `y_sync`.
  - `DEBOUNCE_CYCLES` is ignored.
  - All other behaviour is unchanged.

## Test plan

- Reset/latency:
  - `rst` pulse mid-operation → all outputs 0 immediately.
  - With defaults, `y_in` 0→1 held → `edge_pulse` high only in the cycle after edge 6.
- Debounce (macro on):
  - 3-cycle-wide pulse on `y_in` → no `edge_pulse`, count 0.
  - 4-cycle-wide pulse → exactly one `edge_pulse`.
- Window count:
  - `WINDOW`=100, 7 clean pulses, `cnt_ready`=1 → `cnt_out`=7, `cnt_ovf`=0, `cnt_valid` high for one cycle.
  - An edge on the expiry cycle counts in the closing window.
- Saturation:
  - `CNT_W`=3, 10 pulses in one window → `cnt_out`=7, `cnt_ovf`=1.
  - The next window with 2 pulses → `cnt_out`=2, `cnt_ovf`=0.
- Backpressure:
  - `cnt_ready`=0 across two expiries → second snapshot replaces the first and `miss` pulses once.
  - Accept on the same edge as the third expiry → `cnt_valid` stays 1, `miss`=0.
- `clr` asserted mid-window with `cnt_valid`=1 → `cnt_valid`=0 and `cnt_out`=0 next cycle; the next expiry is `WINDOW` cycles after `clr`.
